address_generator2: RTL and testbench
=====================================

# address_generator2

Read/write address sequencer for an in-place, radix-2, 256-point NTT engine. It issues one memory read address per cycle: top then bottom operand of each butterfly, for all 8 stages. Each address is replayed as a write address after a fixed butterfly-pipeline latency. It sits between the coefficient RAM and the butterfly datapath, and starts once the input-load phase reports completion on `done`.

## Interface
- `ADDR_W`, 8: address width; transform size N = 2^ADDR_W = 256, stage count = ADDR_W = 8.
- `LATENCY`, 4: cycles from a read address to its matching write address (butterfly pipeline depth, ≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `done`  in  1  input-load complete; level, starts a transform when high in IDLE.
- `rdAddress`  out  ADDR_W  registered read address.
- `wrAddress`  out  ADDR_W  registered write address.
- `wrValid`  out  1  write strobe; `wrAddress` is valid when high.

## Operation
- States:
  - IDLE: wait for `done`=1.
  - READ: issue 2^ADDR_W reads for the current stage.
  - DRAIN: `LATENCY` cycles, letting the writes land.
  - FINISH: after the last stage, wait for `done`=0, then go to IDLE.
- Transitions:
  - IDLE→READ on `done`=1; stage=0, k=0, phase=top.
  - In READ, the last bottom read of the stage →DRAIN.
  - DRAIN→READ with stage+1 when the counter expires, or →FINISH if stage was ADDR_W−1.
  - FINISH→IDLE when `done`=0. If `done` stays high, the block stays in FINISH; no automatic rerun.
- Stage s (0..ADDR_W−1), half-span h = 1<<s; butterfly index k = 0..N/2−1:
  - top = ((k>>s)<<(s+1)) | (k & (h−1)).
  - bottom = top + h.
- Read order per butterfly: top cycle, then bottom cycle; k increments after bottom. All arithmetic is ADDR_W-bit unsigned and never overflows.
- Write path: each issued read (address plus internal read-valid) enters a LATENCY-deep delay line. `wrAddress`/`wrValid` are that delay line's output, so writes hit the same addresses, in the same order, as the reads.
- `rdAddress` is 0 outside READ. `wrAddress` holds its last value when `wrValid`=0.
- `done` is ignored outside IDLE and FINISH; a drop mid-transform does not abort.

## Timing
- Reset (async, `rst`=0): state=IDLE, counters=0, delay line cleared, `rdAddress`=0, `wrAddress`=0, `wrValid`=0. Reset mid-transform aborts immediately; after release the block restarts from IDLE.
- Cycle 0 = first edge sampling `done`=1 in IDLE. After that edge, `rdAddress`=top(0,0)=0.
- Each stage is N=256 READ cycles plus LATENCY DRAIN cycles. A full transform is 8·(256+LATENCY) = 2080 cycles at defaults, then FINISH.
- `wrValid` rises exactly LATENCY cycles after the first read. There are exactly 2·(N/2)·ADDR_W = 2048 write strobes per transform, and never two in one cycle.
- DRAIN guarantees that the last write of stage s occurs strictly before the first read of stage s+1 (no RAW hazard, any RAM read mode).

## Structure
- Shared package `ntt_pkg`:
  - N and LOG_N constants.
  - State enum {IDLE, READ, DRAIN, FINISH}.
  - Function computing top(s,k).
- Sub-module `addr_delay_line`: parameterised depth/width shift register, async-reset to 0, carrying {valid, address} for the write path.
- The top level holds the FSM, the stage/k/phase counters and the DRAIN counter.

## Test plan
- Held reset, `rst`=0 with `done` toggling → `rdAddress`=0, `wrAddress`=0, `wrValid`=0 throughout; state stays IDLE.
- Release reset, `done`=1 → stage-0 reads are 0,1,2,3,…,255. `wrValid` is first high 4 cycles after the first read, with `wrAddress`=0.
- Stage 1 → reads 0,2,1,3,4,6,5,7,…; stage 7 → reads 0,128,1,129,…,127,255.
- Full run → 2048 `wrValid` pulses. The write sequence equals the read sequence. FINISH is reached 2080 cycles after start, and `rdAddress` stays 0 while `done` remains 1.
- Stage boundary → the last write of each stage precedes the next stage's first read by ≥1 cycle. Then drop `done`, re-raise it → a second identical transform runs.
- Assert `rst`=0 mid-stage 3 → all outputs go to 0 asynchronously. After release with `done`=1, the run restarts at stage 0 address 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT address sequencer: transform size,
// sequencer states and the butterfly top-operand index function.
package ntt_pkg;

   localparam int LOG_N = 8;
   localparam int N     = 1 << LOG_N;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      FINISH
   } state_t;

   // Top operand of butterfly k in stage s: insert a zero bit at position s
   // of k, so that bottom = top + (1 << s) is the partner operand.
   function automatic int unsigned top_addr(input int unsigned s, input int unsigned k);
      int unsigned h;
      h = 32'd1 << s;
      return ((k >> s) << (s + 32'd1)) | (k & (h - 32'd1));
   endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth shift register carrying {valid, address} from the read side
// to the write side. An address stage only reloads when the valid bit
// entering it is set, so the final stage holds the last written address
// while the valid output is low.
module addr_delay_line #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_addr,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_addr
);

   logic             valid_q [DEPTH];
   logic [WIDTH-1:0] addr_q  [DEPTH];

   // Shift valid every cycle; move addresses only alongside a valid bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            addr_q[0] <= in_addr;
         end
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               addr_q[i] <= addr_q[i-1];
            end
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/address_generator2.sv
// Read/write address sequencer for an in-place radix-2 NTT. Reads the top
// then bottom operand of every butterfly, stage by stage, and replays each
// read address as a write address after the butterfly pipeline latency.
module address_generator2
   import ntt_pkg::*;
#(
   parameter int ADDR_W  = LOG_N,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done,
   output logic [ADDR_W-1:0] rdAddress,
   output logic [ADDR_W-1:0] wrAddress,
   output logic              wrValid
);

   localparam int STAGE_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
   localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int K_W     = ADDR_W - 1;

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0]   DRAIN_INIT = CNT_W'(LATENCY - 1);

   state_t             state;
   logic [STAGE_W-1:0] stage;
   logic [K_W-1:0]     k;
   logic               phase_bottom;
   logic [CNT_W-1:0]   drain_cnt;
   logic               rd_valid;

   logic [ADDR_W-1:0]  half_span;
   logic [ADDR_W-1:0]  next_top;

   assign half_span = ADDR_W'(1) << stage;
   assign next_top  = ADDR_W'(top_addr(32'(stage), 32'(k) + 32'd1));

   // Sequencer FSM; rdAddress and the read-valid bit are registered here and
   // always describe the read currently on the bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         stage        <= '0;
         k            <= '0;
         phase_bottom <= 1'b0;
         drain_cnt    <= '0;
         rdAddress    <= '0;
         rd_valid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (done) begin
                  state        <= READ;
                  stage        <= '0;
                  k            <= '0;
                  phase_bottom <= 1'b0;
                  rdAddress    <= ADDR_W'(top_addr(32'd0, 32'd0));
                  rd_valid     <= 1'b1;
               end
            end
            READ: begin
               if (!phase_bottom) begin
                  rdAddress    <= rdAddress + half_span;
                  phase_bottom <= 1'b1;
               end else if (&k) begin
                  state        <= DRAIN;
                  drain_cnt    <= DRAIN_INIT;
                  k            <= '0;
                  phase_bottom <= 1'b0;
                  rdAddress    <= '0;
                  rd_valid     <= 1'b0;
               end else begin
                  k            <= k + K_W'(1);
                  phase_bottom <= 1'b0;
                  rdAddress    <= next_top;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  if (stage == LAST_STAGE) begin
                     state <= FINISH;
                  end else begin
                     state     <= READ;
                     stage     <= stage + STAGE_W'(1);
                     rdAddress <= '0;
                     rd_valid  <= 1'b1;
                  end
               end else begin
                  drain_cnt <= drain_cnt - CNT_W'(1);
               end
            end
            FINISH: begin
               if (!done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   addr_delay_line #(
      .DEPTH (LATENCY),
      .WIDTH (ADDR_W)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_valid),
      .in_addr   (rdAddress),
      .out_valid (wrValid),
      .out_addr  (wrAddress)
   );

endmodule

// File: tb/tb_address_generator2.sv
// Self-checking bench for address_generator2: compares every cycle of the
// read and write buses against a reference built from the in-place NTT
// block/offset pairing, with random idle gaps, random done activity and
// a random mid-stage-3 reset.
module tb_address_generator2;
   import ntt_pkg::*;

   localparam int ADDR_W       = 8;
   localparam int LATENCY      = 4;
   localparam int NPTS         = 1 << ADDR_W;
   localparam int STAGE_CYCLES = NPTS + LATENCY;
   localparam int TOTAL        = ADDR_W * STAGE_CYCLES;
   localparam int WRITES       = NPTS * ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              done = 1'b0;
   logic [ADDR_W-1:0] rdAddress;
   logic [ADDR_W-1:0] wrAddress;
   logic              wrValid;

   int checkCount = 0;
   int errorCount = 0;
   int expRead [WRITES];
   int expWrLast = 0;

   address_generator2 #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .rdAddress (rdAddress),
      .wrAddress (wrAddress),
      .wrValid   (wrValid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Read order from the textbook loop: blocks of 2h, pair j+i with j+i+h.
   task automatic buildModel();
      int idx;
      idx = 0;
      for (int s = 0; s < ADDR_W; s++) begin
         int h;
         h = 1 << s;
         for (int j = 0; j < NPTS; j += 2 * h) begin
            for (int i = 0; i < h; i++) begin
               expRead[idx] = j + i;
               expRead[idx+1] = j + i + h;
               idx += 2;
            end
         end
      end
   endtask

   // Expected read at transform cycle c, or -1 when no read is issued.
   function automatic int readAt(input int c);
      int st;
      int off;
      if (c < 0 || c >= TOTAL) return -1;
      st  = c / STAGE_CYCLES;
      off = c % STAGE_CYCLES;
      if (off < NPTS) return expRead[st * NPTS + off];
      return -1;
   endfunction

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_rdAddress"}, 32'(rdAddress), 32'd0);
      checkOutput({tag, "_wrAddress"}, 32'(wrAddress), 32'd0);
      checkOutput({tag, "_wrValid"}, 32'(wrValid), 32'd0);
   endtask

   // One transform; abortCycle >= 0 pulls reset asynchronously in that cycle.
   task automatic applyStimulus(input int abortCycle);
      int gap;
      int pulses;
      int rdExp;
      int wrSrc;
      gap    = int'($urandom_range(1, 5));
      pulses = 0;
      done   = 1'b0;
      repeat (gap) @(negedge clk);
      checkOutput("idle_state", 32'(dut.state), 32'(IDLE));
      done = 1'b1;
      for (int c = 0; c < TOTAL + 20; c++) begin
         @(negedge clk);
         rdExp = readAt(c);
         wrSrc = readAt(c - LATENCY);
         checkOutput("rdAddress", 32'(rdAddress), (rdExp < 0) ? 32'd0 : 32'(rdExp));
         checkOutput("wrValid", 32'(wrValid), (wrSrc >= 0) ? 32'd1 : 32'd0);
         if (wrSrc >= 0) begin
            expWrLast = wrSrc;
            pulses++;
         end
         checkOutput("wrAddress", 32'(wrAddress), 32'(expWrLast));
         if (c == TOTAL - 1) checkOutput("drain_before_finish", 32'(dut.state), 32'(DRAIN));
         if (c == TOTAL) checkOutput("finish_reached", 32'(dut.state), 32'(FINISH));
         if (c == TOTAL + 19) checkOutput("finish_held", 32'(dut.state), 32'(FINISH));
         if (c == abortCycle) begin
            #2 rst = 1'b0;
            #1 checkZeroOutputs("async_reset");
            expWrLast = 0;
            repeat (3) begin
               done = 1'($urandom_range(0, 1));
               @(negedge clk);
               checkZeroOutputs("reset_hold");
               checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
            end
            done = 1'b0;
            rst  = 1'b1;
            return;
         end
         done = (c < TOTAL - 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      checkOutput("write_pulses", 32'(pulses), 32'(WRITES));
      done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("back_to_idle", 32'(dut.state), 32'(IDLE));
      checkOutput("idle_rdAddress", 32'(rdAddress), 32'd0);
      checkOutput("idle_wrValid", 32'(wrValid), 32'd0);
      checkOutput("idle_wrAddress_hold", 32'(wrAddress), 32'(expWrLast));
   endtask

   initial begin
      buildModel();
      $display("[TB] holding reset with done toggling");
      rst  = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         done = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkZeroOutputs("held_reset");
         checkOutput("held_reset_state", 32'(dut.state), 32'(IDLE));
      end
      done = 1'b0;
      rst  = 1'b1;
      @(negedge clk);

      $display("[TB] first transform");
      applyStimulus(-1);
      $display("[TB] second transform");
      applyStimulus(-1);
      $display("[TB] transform aborted in stage 3");
      applyStimulus(3 * STAGE_CYCLES + int'($urandom_range(10, 240)));
      $display("[TB] transform after abort");
      applyStimulus(-1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
